// File: rtl/map_ram_writer.sv
// Moves pacman on a 40x30 tile map held in an external RAM with one cycle of read latency.
// Optional build macro PILL_SCORE_EN adds a saturating 16-bit score output.
module map_ram_writer (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  curr_x,
  input  logic [4:0]  curr_y,
  input  logic [5:0]  next_x,
  input  logic [4:0]  next_y,
  input  logic [3:0]  ram_rdata,
  output logic [10:0] ram_addr,
  output logic [3:0]  ram_wdata,
  output logic        ram_wren,
  output logic        busy,
  output logic        done,
  output logic        blocked,
`ifdef PILL_SCORE_EN
  output logic [15:0] score,
`endif
  output logic        pill_eaten
);

  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_WALL   = 4'd1;
  localparam logic [3:0] TILE_PILL   = 4'd2;
  localparam logic [3:0] TILE_PACMAN = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CHK, S_ERASE, S_WRITE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cx_q, cx_d, nx_q, nx_d;
  logic [4:0]  cy_q, cy_d, ny_q, ny_d;
  logic        blocked_q, blocked_d;
  logic [10:0] curr_addr, next_addr;

  // y*40 + x as two shifts and an add; 29*40+39 = 1199 fits in 11 bits.
  function automatic logic [10:0] tile_addr(input logic [5:0] x, input logic [4:0] y);
    logic [10:0] y_w;
    y_w = {6'd0, y};
    return (y_w << 5) + (y_w << 3) + {5'd0, x};
  endfunction

  assign curr_addr = tile_addr(cx_q, cy_q);
  assign next_addr = tile_addr(nx_q, ny_q);
  assign blocked   = blocked_q;

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    blocked_d  = blocked_q;
    ram_addr   = 11'd0;
    ram_wdata  = TILE_EMPTY;
    ram_wren   = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    pill_eaten = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d = curr_x;
          cy_d = curr_y;
          nx_d = next_x;
          ny_d = next_y;
          // Off-map targets are rejected before any RAM traffic.
          if (next_x >= 6'd40 || next_y >= 5'd30) begin
            blocked_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d   = S_RD;
          end
        end
      end
      S_RD: begin
        ram_addr = next_addr;
        state_d  = S_CHK;
      end
      S_CHK: begin
        if (ram_rdata == TILE_WALL) begin
          blocked_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          pill_eaten = (ram_rdata == TILE_PILL);
          state_d    = (cx_q == nx_q && cy_q == ny_q) ? S_WRITE : S_ERASE;
        end
      end
      S_ERASE: begin
        ram_addr  = curr_addr;
        ram_wdata = TILE_EMPTY;
        ram_wren  = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        ram_addr  = next_addr;
        ram_wdata = TILE_PACMAN;
        ram_wren  = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        blocked_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      blocked_q <= blocked_d;
    end
  end

`ifdef PILL_SCORE_EN
  logic [15:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (pill_eaten) score_d = (score_q > 16'hFFF5) ? 16'hFFFF : score_q + 16'd10;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_map_ram_writer.sv
// Directed bench for map_ram_writer with a behavioural one-cycle-latency map RAM.
// Define PILL_SCORE_EN to also check the score output.
module tb_map_ram_writer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  curr_x, next_x;
  logic [4:0]  curr_y, next_y;
  logic [3:0]  ram_rdata;
  logic [10:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic        ram_wren, busy, done, blocked, pill_eaten;
`ifdef PILL_SCORE_EN
  logic [15:0] score;
`endif

  map_ram_writer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .next_x     (next_x),
    .next_y     (next_y),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .done       (done),
    .blocked    (blocked),
`ifdef PILL_SCORE_EN
    .score      (score),
`endif
    .pill_eaten (pill_eaten)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [3:0] mem [0:2047];
  always @(posedge CLOCK_50) ram_rdata <= mem[ram_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-request observations, cycle numbers relative to the accepting edge N.
  int          done_cnt, done_cyc, pill_cnt, pill_cyc, wr_cnt, addr_nz;
  logic        blk_at_done, blk_after, busy_c1;
  logic [10:0] rd_addr_c1;
  logic [10:0] wr_addr [0:7];
  logic [3:0]  wr_data [0:7];

  task automatic sample(input int cyc);
    if (cyc == 1) begin
      busy_c1    = busy;
      rd_addr_c1 = ram_addr;
    end
    if (ram_addr != 11'd0) addr_nz++;
    if (done_cyc != 0 && cyc == done_cyc + 1) blk_after = blocked;
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      blk_at_done = blocked;
    end
    if (pill_eaten) begin
      pill_cnt++;
      pill_cyc = cyc;
    end
    if (ram_wren) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = ram_addr;
        wr_data[wr_cnt] = ram_wdata;
      end
      wr_cnt++;
      mem[ram_addr] = ram_wdata;
    end
  endtask

  // Issues one request and observes a bounded window; restart_cyc>0 re-pulses start with
  // different coordinates at that cycle to prove busy requests are dropped.
  task automatic run_req(input logic [5:0] cx, input logic [4:0] cy,
                         input logic [5:0] nx, input logic [4:0] ny,
                         input int restart_cyc);
    done_cnt = 0; done_cyc = 0; pill_cnt = 0; pill_cyc = 0; wr_cnt = 0; addr_nz = 0;
    blk_at_done = 1'bx; blk_after = 1'bx; busy_c1 = 1'b0; rd_addr_c1 = '0;
    @(negedge CLOCK_50);
    curr_x = cx; curr_y = cy; next_x = nx; next_y = ny; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    curr_x = 6'd1; curr_y = 5'd1; next_x = 6'd2; next_y = 5'd1;
    for (int c = 1; c <= 12; c++) begin
      sample(c);
      start = (c == restart_cyc);
      @(negedge CLOCK_50);
      start = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 4'd0;
    mem[820] = 4'd3;
    mem[821] = 4'd2;
    mem[780] = 4'd1;
    reset = 1'b1; start = 1'b0;
    curr_x = '0; curr_y = '0; next_x = '0; next_y = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_wren", ram_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_blocked", blocked, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_pill", pill_eaten, 0);
`ifdef PILL_SCORE_EN
    check("rst_score", score, 0);
`endif
    reset = 1'b0;

    // Normal move left onto an empty tile.
    run_req(6'd20, 5'd20, 6'd19, 5'd20, 0);
    check("norm_busy", busy_c1, 1);
    check("norm_rdaddr", rd_addr_c1, 819);
    check("norm_done_cyc", done_cyc, 5);
    check("norm_done_cnt", done_cnt, 1);
    check("norm_blocked", blk_at_done, 0);
    check("norm_wr_cnt", wr_cnt, 2);
    check("norm_wr0_addr", wr_addr[0], 820);
    check("norm_wr0_data", wr_data[0], 0);
    check("norm_wr1_addr", wr_addr[1], 819);
    check("norm_wr1_data", wr_data[1], 3);
    check("norm_pill_cnt", pill_cnt, 0);

    // Restore pacman at (20,20), then eat the pill to the right.
    mem[820] = 4'd3; mem[819] = 4'd0;
    run_req(6'd20, 5'd20, 6'd21, 5'd20, 0);
    check("pill_cyc", pill_cyc, 2);
    check("pill_cnt", pill_cnt, 1);
    check("pill_done_cyc", done_cyc, 5);
    check("pill_wr_cnt", wr_cnt, 2);
    check("pill_wr0_addr", wr_addr[0], 820);
    check("pill_wr0_data", wr_data[0], 0);
    check("pill_wr1_addr", wr_addr[1], 821);
    check("pill_wr1_data", wr_data[1], 3);
`ifdef PILL_SCORE_EN
    check("pill_score", score, 10);
`endif

    // Wall above.
    mem[820] = 4'd3; mem[821] = 4'd0;
    run_req(6'd20, 5'd20, 6'd20, 5'd19, 0);
    check("wall_done_cyc", done_cyc, 3);
    check("wall_blocked", blk_at_done, 1);
    check("wall_blk_clear", blk_after, 0);
    check("wall_wr_cnt", wr_cnt, 0);

    // Off-map targets in x and in y.
    run_req(6'd39, 5'd5, 6'd40, 5'd5, 0);
    check("oorx_done_cyc", done_cyc, 1);
    check("oorx_blocked", blk_at_done, 1);
    check("oorx_wr_cnt", wr_cnt, 0);
    check("oorx_addr_nz", addr_nz, 0);
    run_req(6'd3, 5'd29, 6'd3, 5'd30, 0);
    check("oory_done_cyc", done_cyc, 1);
    check("oory_blocked", blk_at_done, 1);
    check("oory_wr_cnt", wr_cnt, 0);
    check("oory_addr_nz", addr_nz, 0);

    // Staying in place writes only the pacman tile.
    run_req(6'd5, 5'd5, 6'd5, 5'd5, 0);
    check("same_done_cyc", done_cyc, 4);
    check("same_wr_cnt", wr_cnt, 1);
    check("same_wr0_addr", wr_addr[0], 205);
    check("same_wr0_data", wr_data[0], 3);
    check("same_blocked", blk_at_done, 0);

    // Start pulsed during ERASE (cycle 3) must be dropped.
    run_req(6'd10, 5'd10, 6'd11, 5'd10, 3);
    check("busy_done_cnt", done_cnt, 1);
    check("busy_done_cyc", done_cyc, 5);
    check("busy_wr_cnt", wr_cnt, 2);
    check("busy_idle", busy, 0);

    // Reset while in WRITE aborts the request.
    done_cnt = 0;
    @(negedge CLOCK_50);
    curr_x = 6'd20; curr_y = 5'd20; next_x = 6'd19; next_y = 5'd20; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("mid_in_write", ram_wren, 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid_wren", ram_wren, 0);
    check("mid_busy", busy, 0);
    if (done) done_cnt++;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLOCK_50);
      if (done) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);
    run_req(6'd20, 5'd20, 6'd19, 5'd20, 0);
    check("post_done_cyc", done_cyc, 5);
    check("post_wr_cnt", wr_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_ram_writer.md
MAP_RAM_WRITER -- requirements
Module: map_ram_writer

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  move request; sampled only in IDLE.
- curr_x  in  6  current pacman column.
- curr_y  in  5  current pacman row.
- next_x  in  6  target column.
- next_y  in  5  target row.
- ram_rdata  in  4  map RAM read data; valid one cycle after ram_addr is presented.
- ram_addr  out  11  map RAM address.
- ram_wdata  out  4  map RAM write data.
- ram_wren  out  1  map RAM write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- blocked  out  1  qualifies done: the move was rejected.
- pill_eaten  out  1  one-cycle pulse: the target held a pill.
- score  out  16  present only with PILL_SCORE_EN.

Function
REQ-002 Map geometry SHALL be 40 columns x 30 rows; address = y*40 + x, computed as (y<<5)+(y<<3)+x, 11 bits wide, with no overflow possible for legal coordinates.
REQ-003 Tile codes SHALL be: 0 EMPTY, 1 WALL, 2 PILL, 3 PACMAN; codes 4-15 are treated as non-wall.
REQ-004 States SHALL be IDLE, RD, CHK, ERASE, WRITE, DONE.
REQ-005 IDLE: if start=1, SHALL latch curr_x/y and next_x/y and go to RD; otherwise stay in IDLE.
REQ-006 Inputs SHALL be ignored after latching; start asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-007 RD: ram_addr = next address, ram_wren=0; SHALL go to CHK unconditionally.
REQ-008 CHK: SHALL evaluate ram_rdata.
- If ram_rdata = WALL: set blocked=1 and go to DONE; no write SHALL ever occur.
- Else if ram_rdata = PILL: pulse pill_eaten for this cycle.
- Non-wall: if curr == next, go to WRITE; otherwise go to ERASE.
REQ-009 Out-of-range target (next_x>=40 or next_y>=30) SHALL be detected at latch time.
- Go directly from IDLE to DONE with blocked=1.
- No RAM read and no RAM write SHALL occur.
REQ-010 ERASE: ram_addr = curr address, ram_wdata=EMPTY, ram_wren=1 for exactly one cycle, then go to WRITE.
REQ-011 WRITE: ram_addr = next address, ram_wdata=PACMAN, ram_wren=1 for exactly one cycle, then go to DONE.
REQ-012 DONE: done=1 for exactly one cycle with blocked valid alongside it, then go to IDLE; blocked SHALL clear on the IDLE entry.
REQ-013 Latency from a start accepted at cycle N SHALL be:
- Normal move: done at N+5.
- curr == next: done at N+4.
- Wall: done at N+3.
- Out-of-range: done at N+1.
REQ-014 In IDLE, RD, CHK and DONE: ram_wren=0, ram_wdata=0; ram_addr=0 in IDLE and DONE.
REQ-015 At most two RAM writes SHALL occur per accepted request.

Reset
REQ-016 Reset SHALL take priority over all state transitions.
REQ-017 Reset SHALL force: state=IDLE, ram_addr=0, ram_wdata=0, ram_wren=0, busy=0, done=0, blocked=0, pill_eaten=0, latched coordinates=0, score=0.
REQ-018 Reset asserted mid-operation (including during ERASE or WRITE) SHALL abort the request.
- No done pulse for the aborted request.
- ram_wren=0 in the cycle after reset is sampled.

Configuration
REQ-019 Macro PILL_SCORE_EN SHALL control the score feature.
- Defined: score port exists; score increments by 10 in the cycle pill_eaten=1; saturates at 16'hFFFF.
- Undefined: score port and its register are absent; all other behaviour is identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Normal move: start, curr=(20,20), next=(19,20), target tile EMPTY -> write addr 820 data 0, then addr 819 data 3; done at N+5; blocked=0.
- Pill: target (21,20) holds PILL -> pill_eaten pulse at N+2; writes 820<-0, 821<-3; score=10 with PILL_SCORE_EN.
- Wall: target (20,19) holds WALL -> done at N+3 with blocked=1; ram_wren never asserted.
- Edge: next=(40,5) or next=(3,30) -> done and blocked at N+1; no RAM access; curr==next=(5,5) -> single write addr 205 data 3; done at N+4.
- Busy start: start re-asserted during ERASE -> ignored; exactly one done pulse.
- Mid-operation reset: reset during WRITE -> next cycle state IDLE, ram_wren=0, no done; a new start then completes normally.
